gray_sync_fifo: RTL and testbench
=================================

Name: gray_sync_fifo

Overview:
Single-clock FIFO whose read and write pointers are held as Gray-coded counters. It sits directly downstream of the Gray increment counter and consumes the same pointer scheme.
- Full and empty are derived purely from Gray pointer comparison, so the identical pointer logic can later be split across clock domains.
- Both Gray pointers are exported for downstream synchronisers and monitors.

Parameters:
WIDTH, 8, data bus width; must be greater than zero.
ADDR_WIDTH, 2, address width; DEPTH = 2**ADDR_WIDTH entries; must be greater than zero.

Ports:
iw_clk  input  1  clock; all logic on rising edge.
iw_reset  input  1  synchronous, active-high reset.
iw_wr  input  1  write request.
iwv_wr_data  input  WIDTH  write data.
ow_full  output  1  FIFO full.
ow_wr_err  output  1  one-cycle pulse: write requested while full.
iw_rd  input  1  read request.
owv_rd_data  output  WIDTH  registered read data.
ow_rd_valid  output  1  owv_rd_data holds newly read word this cycle.
ow_empty  output  1  FIFO empty.
ow_rd_err  output  1  one-cycle pulse: read requested while empty.
owv_wr_ptr_gray  output  ADDR_WIDTH+1  write pointer, Gray code.
owv_rd_ptr_gray  output  ADDR_WIDTH+1  read pointer, Gray code.

Behaviour:
- Clocking and reset: one clock, iw_clk. Reset is iw_reset, synchronous and active-high.
- Reset values: both pointers 0, ow_empty=1, ow_full=0, owv_rd_data=0, ow_rd_valid=0, ow_wr_err=0, ow_rd_err=0.
- Reset mid-operation: all stored words are discarded. Memory contents need not be cleared.
- Pointer storage: each pointer is an (ADDR_WIDTH+1)-bit Gray register. Its next value is Bin2Gray(Gray2Bin(ptr) + advance).
- Memory address: the low ADDR_WIDTH bits of the binary pointer. The MSB is the wrap bit.
- Empty: ow_empty = (wr_ptr_gray == rd_ptr_gray).
- Full: ow_full = wr_ptr_gray equals rd_ptr_gray with its top two bits inverted and the remaining bits unchanged.
- Flag timing: ow_full and ow_empty are combinational from registered pointers only. There is no combinational path from any input to any output.
- Write accept: iw_wr && !ow_full. The word is stored at the write address and the write pointer advances by one at the clock edge.
- Read accept: iw_rd && !ow_empty. Memory at the read address is registered into owv_rd_data, ow_rd_valid=1 on the next cycle, and the read pointer advances.
- Read latency: 1 cycle. When no read is accepted, ow_rd_valid=0 and owv_rd_data holds its previous value.
- Rejected write: iw_wr while full leaves state unchanged; ow_wr_err=1 for the following cycle.
- Rejected read: iw_rd while empty leaves state unchanged; ow_rd_err=1 for the following cycle.
- Simultaneous read and write:
  - Not full, not empty: both accepted, occupancy unchanged.
  - Full: read accepted, write rejected with error; next state has DEPTH-1 entries.
  - Empty: write accepted, read rejected with error; there is no fall-through.
- Wrap-around: pointers wrap modulo 2**(ADDR_WIDTH+1) naturally. Exactly one Gray bit changes per advance.
- Occupancy range: 0..DEPTH inclusive; all DEPTH entries are usable.

Optional Feature:
Macro: GRAY_FIFO_LEVEL_EN.
- Defined: adds output owv_level, width ADDR_WIDTH+1.
  - owv_level = Gray2Bin(wr_ptr) - Gray2Bin(rd_ptr), modulo 2**(ADDR_WIDTH+1).
  - Range 0..DEPTH, combinational from registered pointers, reset value 0.
  - Also adds outputs ow_almost_full (owv_level >= DEPTH-1) and ow_almost_empty (owv_level <= 1). Both are 0 and 1 respectively at reset.
- Undefined: none of these ports or logic exist. All other behaviour is identical.

Test Plan:
All scenarios use WIDTH=8, ADDR_WIDTH=2.
1. Reset then idle -> ow_empty=1, ow_full=0, both pointers 3'b000, ow_rd_valid=0.
2. Write 8'hA1, A2, A3, A4 on consecutive cycles -> ow_full=1 after the 4th edge; owv_wr_ptr_gray steps 001, 011, 010, 110; owv_rd_ptr_gray=000.
3. From full, write 8'hFF -> ow_wr_err pulses once, pointers unchanged. Then read 4 words -> owv_rd_data A1, A2, A3, A4 each one cycle after its accepted read, then ow_empty=1.
4. Read while empty -> ow_rd_err pulses once, ow_rd_valid=0, owv_rd_ptr_gray unchanged.
5. Continuous simultaneous write/read of 8'h00..8'h0F, starting one write ahead -> data returned in order, no errors, pointers wrap through 100 -> 000 with single-bit Gray changes; check Gray property every cycle.
6. Assert iw_reset while holding 3 entries, with iw_wr=1 and iw_rd=1 -> next cycle ow_empty=1, pointers 000, ow_rd_valid=0. With GRAY_FIFO_LEVEL_EN, owv_level=0 and the sequence from scenario 2 shows owv_level 1, 2, 3, 4.

Source files
------------

// File: rtl/gray_sync_fifo.sv
// gray_sync_fifo
//   Single-clock FIFO whose read and write pointers are kept as Gray-coded
//   (ADDR_WIDTH+1)-bit counters. Full and empty come only from comparing the
//   two Gray pointers, so the same pointer logic can later be split across
//   clock domains. Both Gray pointers are exported for synchronisers/monitors.
//
// Parameters
//   WIDTH       data bus width (> 0)
//   ADDR_WIDTH  address width, DEPTH = 2**ADDR_WIDTH (> 0)
//
// Ports
//   iw_clk           clock, rising edge
//   iw_reset         synchronous active-high reset
//   iw_wr            write request
//   iwv_wr_data      write data
//   ow_full          FIFO full
//   ow_wr_err        one-cycle pulse after a write requested while full
//   iw_rd            read request
//   owv_rd_data      registered read data (1-cycle latency)
//   ow_rd_valid      owv_rd_data holds a newly read word this cycle
//   ow_empty         FIFO empty
//   ow_rd_err        one-cycle pulse after a read requested while empty
//   owv_wr_ptr_gray  write pointer, Gray code
//   owv_rd_ptr_gray  read pointer, Gray code
//
// Optional build macro GRAY_FIFO_LEVEL_EN adds:
//   owv_level        occupancy, 0..DEPTH
//   ow_almost_full   owv_level >= DEPTH-1
//   ow_almost_empty  owv_level <= 1

module gray_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  iw_clk,
    input  logic                  iw_reset,
    input  logic                  iw_wr,
    input  logic [WIDTH-1:0]      iwv_wr_data,
    output logic                  ow_full,
    output logic                  ow_wr_err,
    input  logic                  iw_rd,
    output logic [WIDTH-1:0]      owv_rd_data,
    output logic                  ow_rd_valid,
    output logic                  ow_empty,
    output logic                  ow_rd_err,
`ifdef GRAY_FIFO_LEVEL_EN
    output logic [ADDR_WIDTH:0]   owv_level,
    output logic                  ow_almost_full,
    output logic                  ow_almost_empty,
`endif
    output logic [ADDR_WIDTH:0]   owv_wr_ptr_gray,
    output logic [ADDR_WIDTH:0]   owv_rd_ptr_gray
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // Full pattern: top two Gray bits inverted, the rest equal.
    localparam logic [ADDR_WIDTH:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);

    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        b = g;
        // Prefix XOR from the MSB down.
        for (int unsigned i = 1; i <= ADDR_WIDTH; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr_gray;
    logic [ADDR_WIDTH:0]   r_rd_ptr_gray;
    logic [WIDTH-1:0]      r_rd_data;
    logic                  r_rd_valid;
    logic                  r_wr_err;
    logic                  r_rd_err;

    logic [ADDR_WIDTH:0]   w_wr_bin;
    logic [ADDR_WIDTH:0]   w_rd_bin;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_accept;
    logic                  w_rd_accept;

    always_comb begin
        w_wr_bin    = gray2bin(r_wr_ptr_gray);
        w_rd_bin    = gray2bin(r_rd_ptr_gray);
        w_empty     = (r_wr_ptr_gray == r_rd_ptr_gray);
        w_full      = (r_wr_ptr_gray == (r_rd_ptr_gray ^ FULL_MASK));
        w_wr_accept = iw_wr && !w_full;
        w_rd_accept = iw_rd && !w_empty;
    end

    // Storage is not reset; discarding words only needs the pointers cleared.
    always_ff @(posedge iw_clk) begin
        if (w_wr_accept && !iw_reset) begin
            r_mem[w_wr_bin[ADDR_WIDTH-1:0]] <= iwv_wr_data;
        end
    end

    always_ff @(posedge iw_clk) begin
        if (iw_reset) begin
            r_wr_ptr_gray <= '0;
            r_rd_ptr_gray <= '0;
            r_rd_data     <= '0;
            r_rd_valid    <= 1'b0;
            r_wr_err      <= 1'b0;
            r_rd_err      <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr_gray <= bin2gray(w_wr_bin + 1'b1);
            end
            if (w_rd_accept) begin
                r_rd_ptr_gray <= bin2gray(w_rd_bin + 1'b1);
                r_rd_data     <= r_mem[w_rd_bin[ADDR_WIDTH-1:0]];
            end
            r_rd_valid <= w_rd_accept;
            r_wr_err   <= iw_wr && w_full;
            r_rd_err   <= iw_rd && w_empty;
        end
    end

    assign ow_full         = w_full;
    assign ow_empty        = w_empty;
    assign ow_wr_err       = r_wr_err;
    assign ow_rd_err       = r_rd_err;
    assign owv_rd_data     = r_rd_data;
    assign ow_rd_valid     = r_rd_valid;
    assign owv_wr_ptr_gray = r_wr_ptr_gray;
    assign owv_rd_ptr_gray = r_rd_ptr_gray;

`ifdef GRAY_FIFO_LEVEL_EN
    logic [ADDR_WIDTH:0] w_level;

    always_comb begin
        // Modular subtraction is exact because occupancy never exceeds DEPTH.
        w_level = w_wr_bin - w_rd_bin;
    end

    assign owv_level       = w_level;
    assign ow_almost_full  = (w_level >= PW'(DEPTH - 1));
    assign ow_almost_empty = (w_level <= PW'(1));
`endif

endmodule

// File: tb/tb_gray_sync_fifo.sv
// tb_gray_sync_fifo
//   Directed bench for gray_sync_fifo (WIDTH=8, ADDR_WIDTH=2). A table of
//   per-cycle inputs and hand-computed expected outputs covers reset, fill,
//   overflow, drain, underflow, simultaneous access at empty/full and reset
//   mid-operation; a hand-written loop covers continuous streaming with
//   pointer wrap and the single-bit Gray property.

module tb_gray_sync_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr;
    logic [7:0] wr_data;
    logic       rd;
    logic       full;
    logic       wr_err;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       rd_err;
    logic [2:0] wr_gray;
    logic [2:0] rd_gray;
`ifdef GRAY_FIFO_LEVEL_EN
    logic [2:0] level;
    logic       almost_full;
    logic       almost_empty;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_sync_fifo #(
        .WIDTH      (8),
        .ADDR_WIDTH (2)
    ) dut (
        .iw_clk          (clk),
        .iw_reset        (reset),
        .iw_wr           (wr),
        .iwv_wr_data     (wr_data),
        .ow_full         (full),
        .ow_wr_err       (wr_err),
        .iw_rd           (rd),
        .owv_rd_data     (rd_data),
        .ow_rd_valid     (rd_valid),
        .ow_empty        (empty),
        .ow_rd_err       (rd_err),
`ifdef GRAY_FIFO_LEVEL_EN
        .owv_level       (level),
        .ow_almost_full  (almost_full),
        .ow_almost_empty (almost_empty),
`endif
        .owv_wr_ptr_gray (wr_gray),
        .owv_rd_ptr_gray (rd_gray)
    );

    typedef struct {
        logic       rst;
        logic       wr;
        logic       rd;
        logic [7:0] wdata;
        logic       full;
        logic       empty;
        logic       wr_err;
        logic       rd_err;
        logic       valid;
        logic [7:0] data;
        logic [2:0] wg;
        logic [2:0] rg;
        logic [2:0] lvl;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic r, input logic w, input logic d,
                        input logic [7:0] wd, input logic f, input logic e,
                        input logic we, input logic re, input logic v,
                        input logic [7:0] dat, input logic [2:0] wg,
                        input logic [2:0] rg, input logic [2:0] lv);
        vecs[i].rst = r;   vecs[i].wr = w;       vecs[i].rd = d;
        vecs[i].wdata = wd; vecs[i].full = f;    vecs[i].empty = e;
        vecs[i].wr_err = we; vecs[i].rd_err = re; vecs[i].valid = v;
        vecs[i].data = dat; vecs[i].wg = wg;     vecs[i].rg = rg;
        vecs[i].lvl = lv;
    endtask

    // Drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic w, input logic d, input logic [7:0] wd);
        @(negedge clk);
        reset = r; wr = w; rd = d; wr_data = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_level(input string tag, input logic [2:0] lv);
`ifdef GRAY_FIFO_LEVEL_EN
        check({tag, "_level"}, level, lv);
        check({tag, "_afull"}, almost_full, lv >= 3'd3);
        check({tag, "_aempty"}, almost_empty, lv <= 3'd1);
`else
        if (lv === 3'bxxx) check({tag, "_level"}, 0, 1);
`endif
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; rd = 1'b0; wr_data = '0;

        //     i   rst wr rd wdata  full emp werr rerr vld data   wg      rg      lvl
        setv( 0, 1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 3'b000, 3'b000, 3'd0);
        setv( 1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 3'b000, 3'b000, 3'd0);
        setv( 2, 0, 1, 0, 8'hA1, 0, 0, 0, 0, 0, 8'h00, 3'b001, 3'b000, 3'd1);
        setv( 3, 0, 1, 0, 8'hA2, 0, 0, 0, 0, 0, 8'h00, 3'b011, 3'b000, 3'd2);
        setv( 4, 0, 1, 0, 8'hA3, 0, 0, 0, 0, 0, 8'h00, 3'b010, 3'b000, 3'd3);
        setv( 5, 0, 1, 0, 8'hA4, 1, 0, 0, 0, 0, 8'h00, 3'b110, 3'b000, 3'd4);
        setv( 6, 0, 1, 0, 8'hFF, 1, 0, 1, 0, 0, 8'h00, 3'b110, 3'b000, 3'd4);
        setv( 7, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 3'b110, 3'b000, 3'd4);
        setv( 8, 0, 0, 1, 8'h00, 0, 0, 0, 0, 1, 8'hA1, 3'b110, 3'b001, 3'd3);
        setv( 9, 0, 0, 1, 8'h00, 0, 0, 0, 0, 1, 8'hA2, 3'b110, 3'b011, 3'd2);
        setv(10, 0, 0, 1, 8'h00, 0, 0, 0, 0, 1, 8'hA3, 3'b110, 3'b010, 3'd1);
        setv(11, 0, 0, 1, 8'h00, 0, 1, 0, 0, 1, 8'hA4, 3'b110, 3'b110, 3'd0);
        setv(12, 0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 8'hA4, 3'b110, 3'b110, 3'd0);
        setv(13, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'hA4, 3'b110, 3'b110, 3'd0);
        // empty: write accepted, read rejected (no fall-through)
        setv(14, 0, 1, 1, 8'hB1, 0, 0, 0, 1, 0, 8'hA4, 3'b111, 3'b110, 3'd1);
        setv(15, 0, 1, 1, 8'hB2, 0, 0, 0, 0, 1, 8'hB1, 3'b101, 3'b111, 3'd1);
        setv(16, 0, 1, 0, 8'hB3, 0, 0, 0, 0, 0, 8'hB1, 3'b100, 3'b111, 3'd2);
        setv(17, 0, 1, 0, 8'hB4, 0, 0, 0, 0, 0, 8'hB1, 3'b000, 3'b111, 3'd3);
        setv(18, 0, 1, 0, 8'hB5, 1, 0, 0, 0, 0, 8'hB1, 3'b001, 3'b111, 3'd4);
        // full: read accepted, write rejected
        setv(19, 0, 1, 1, 8'hB6, 0, 0, 1, 0, 1, 8'hB2, 3'b001, 3'b101, 3'd3);
        setv(20, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'hB2, 3'b001, 3'b101, 3'd3);
        // reset with 3 entries held and both requests active
        setv(21, 1, 1, 1, 8'hC1, 0, 1, 0, 0, 0, 8'h00, 3'b000, 3'b000, 3'd0);
        setv(22, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 3'b000, 3'b000, 3'd0);

        for (int i = 0; i < NV; i++) begin
            string t;
            t = $sformatf("v%0d", i);
            step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].wdata);
            check({t, "_full"},    full,     vecs[i].full);
            check({t, "_empty"},   empty,    vecs[i].empty);
            check({t, "_wr_err"},  wr_err,   vecs[i].wr_err);
            check({t, "_rd_err"},  rd_err,   vecs[i].rd_err);
            check({t, "_valid"},   rd_valid, vecs[i].valid);
            check({t, "_data"},    rd_data,  vecs[i].data);
            check({t, "_wr_gray"}, wr_gray,  vecs[i].wg);
            check({t, "_rd_gray"}, rd_gray,  vecs[i].rg);
            check_level(t, vecs[i].lvl);
        end

        // Streaming: 16 writes one ahead of 16 reads, pointers wrap twice.
        begin
            logic [2:0] prev_wg;
            logic [2:0] prev_rg;
            logic [2:0] wb;
            logic [2:0] rb;
            int         wraps;
            prev_wg = wr_gray;
            prev_rg = rd_gray;
            wraps   = 0;
            for (int i = 0; i <= 16; i++) begin
                string t;
                logic [7:0] wd;
                t  = $sformatf("s%0d", i);
                wd = 8'(i);
                step(1'b0, i < 16, i > 0, wd);
                wb = 3'((i < 16) ? i + 1 : 16);
                rb = 3'(i);
                check({t, "_wr_gray"}, wr_gray, wb ^ (wb >> 1));
                check({t, "_rd_gray"}, rd_gray, rb ^ (rb >> 1));
                check({t, "_wg_1bit"}, $countones(wr_gray ^ prev_wg) <= 1, 1'b1);
                check({t, "_rg_1bit"}, $countones(rd_gray ^ prev_rg) <= 1, 1'b1);
                check({t, "_errs"},    {wr_err, rd_err}, 2'b00);
                check({t, "_full"},    full, 1'b0);
                check({t, "_empty"},   empty, i == 16);
                check({t, "_valid"},   rd_valid, i > 0);
                if (i > 0) check({t, "_data"}, rd_data, 8'(i - 1));
                if (prev_rg == 3'b100 && rd_gray == 3'b000) wraps++;
                prev_wg = wr_gray;
                prev_rg = rd_gray;
            end
            check("stream_rd_wrap_100_000", wraps, 2);
        end

        // Idle cycle after streaming: no stale valid, still empty.
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("post_stream_valid", rd_valid, 1'b0);
        check("post_stream_empty", empty, 1'b1);
        check("post_stream_data",  rd_data, 8'h0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
